// File: rtl/accumulator_bank_if.sv
// Decoder-to-accumulator-bank bus.
// The decoder drives the command side. The bank drives the tristate data
// bus and the global flags back.
interface accumulator_bank_if #(
    parameter int X       = 8,
    parameter int NUM_ACC = 4
);
    localparam int SEL_W = $clog2(NUM_ACC);

    logic [X-1:0]     data_in;
    logic [SEL_W-1:0] acc_sel;
    logic [2:0]       op;
    logic             op_valid;
    logic             output_enable;
    wire  [X-1:0]     data_out;
    logic             carry_flag;
    logic             zero_flag;

    modport master (
        output data_in, acc_sel, op, op_valid, output_enable,
        input  data_out, carry_flag, zero_flag
    );

    modport slave (
        input  data_in, acc_sel, op, op_valid, output_enable,
        output data_out, carry_flag, zero_flag
    );
endinterface

// File: rtl/accumulator_bank.sv
// Bank of NUM_ACC independent X-bit accumulators with load, nibble-immediate
// load and add/sub/shift operations.
// carry_flag and zero_flag are global: they are shared by all accumulators.
// The selected accumulator drives the shared bus through a tristate output.
module accumulator_bank #(
    parameter int X       = 8,
    parameter int NUM_ACC = 4
) (
    input  logic                clk,
    input  logic                reset,
    accumulator_bank_if.slave   bus
);
    localparam int SEL_W = $clog2(NUM_ACC);
    localparam int H     = X / 2;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_LDLO = 3'b010;
    localparam logic [2:0] OP_LDHI = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;
    localparam logic [2:0] OP_SHR  = 3'b111;

    logic [X-1:0] acc_reg [NUM_ACC];
    logic         carry_reg;
    logic         zero_reg;

    logic [X-1:0] acc_cur;
    logic [X-1:0] acc_next;
    logic         carry_next;
    logic         arith_op;

    assign acc_cur  = acc_reg[bus.acc_sel];
    // Ops 100-111 are the arithmetic group; only they touch the flags.
    assign arith_op = bus.op[2];

    // Result of the requested op on the selected accumulator.
    always_comb begin
        acc_next   = acc_cur;
        carry_next = carry_reg;
        case (bus.op)
            OP_NOP:  acc_next = acc_cur;
            OP_LOAD: acc_next = bus.data_in;
            OP_LDLO: acc_next = {{(X - H){1'b0}}, bus.data_in[H-1:0]};
            OP_LDHI: acc_next = {bus.data_in[H-1:0], acc_cur[H-1:0]};
            OP_ADD:  {carry_next, acc_next} = {1'b0, acc_cur} + {1'b0, bus.data_in};
            OP_SUB:  begin
                acc_next   = acc_cur - bus.data_in;
                carry_next = (acc_cur < bus.data_in);
            end
            OP_SHL:  begin
                acc_next   = {acc_cur[X-2:0], 1'b0};
                carry_next = acc_cur[X-1];
            end
            OP_SHR:  begin
                acc_next   = {1'b0, acc_cur[X-1:1]};
                carry_next = acc_cur[0];
            end
            default: acc_next = acc_cur;
        endcase
    end

    // One register per accumulator; only the selected one is written.
    for (genvar gi = 0; gi < NUM_ACC; gi++) begin : g_acc
        // Accumulator gi: cleared on reset, written when selected with a valid op.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                acc_reg[gi] <= '0;
            end else if (bus.op_valid && (bus.acc_sel == SEL_W'(gi))) begin
                acc_reg[gi] <= acc_next;
            end
        end
    end

    // Global flags, updated only by the arithmetic group.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            carry_reg <= 1'b0;
            zero_reg  <= 1'b0;
        end else if (bus.op_valid && arith_op) begin
            carry_reg <= carry_next;
            zero_reg  <= (acc_next == '0);
        end
    end

    assign bus.carry_flag = carry_reg;
    assign bus.zero_flag  = zero_reg;

    // Tristate read path: no bypass, so a write appears only after its edge.
    assign bus.data_out = bus.output_enable ? acc_cur : {X{1'bz}};
endmodule

// File: tb/tb_accumulator_bank.sv
// Directed testbench for accumulator_bank (X=8, NUM_ACC=4).
module tb_accumulator_bank;
    localparam logic [2:0] NOP  = 3'b000;
    localparam logic [2:0] LOAD = 3'b001;
    localparam logic [2:0] LDLO = 3'b010;
    localparam logic [2:0] LDHI = 3'b011;
    localparam logic [2:0] ADD  = 3'b100;
    localparam logic [2:0] SUB  = 3'b101;
    localparam logic [2:0] SHL  = 3'b110;
    localparam logic [2:0] SHR  = 3'b111;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    accumulator_bank_if #(.X(8), .NUM_ACC(4)) bus ();

    accumulator_bank #(.X(8), .NUM_ACC(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
        $display("check %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic check_flags(input string tag, input logic c, input logic z);
        check1({tag, ".carry"}, bus.carry_flag, c);
        check1({tag, ".zero"}, bus.zero_flag, z);
    endtask

    // Apply one op on a single rising edge, then sample 1 time unit later.
    task automatic do_op(input logic [1:0] sel, input logic [2:0] o, input logic [7:0] d,
                         input logic valid);
        @(negedge clk);
        bus.acc_sel  = sel;
        bus.op       = o;
        bus.data_in  = d;
        bus.op_valid = valid;
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        bus.op       = NOP;
    endtask

    task automatic read_acc(input string tag, input logic [1:0] sel, input logic [7:0] exp);
        bus.output_enable = 1'b1;
        bus.acc_sel       = sel;
        #1;
        check8(tag, bus.data_out, exp);
    endtask

    initial begin
        reset             = 1'b1;
        bus.data_in       = '0;
        bus.acc_sel       = '0;
        bus.op            = NOP;
        bus.op_valid      = 1'b0;
        bus.output_enable = 1'b1;

        // Reset state across every select
        for (int i = 0; i < 4; i++) begin
            read_acc($sformatf("reset.acc%0d", i), 2'(i), 8'h00);
        end
        check_flags("reset", 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Whole and nibble loads on acc0
        do_op(2'd0, LOAD, 8'hA5, 1'b1);
        read_acc("load.acc0", 2'd0, 8'hA5);
        do_op(2'd0, LDLO, 8'h3C, 1'b1);
        read_acc("ldlo.acc0", 2'd0, 8'h0C);
        do_op(2'd0, LDHI, 8'h07, 1'b1);
        read_acc("ldhi.acc0", 2'd0, 8'h7C);
        for (int i = 1; i < 4; i++) begin
            read_acc($sformatf("untouched.acc%0d", i), 2'(i), 8'h00);
        end
        check_flags("loads", 1'b0, 1'b0);

        // Output disabled: bus must not carry acc0's value
        bus.output_enable = 1'b0;
        bus.acc_sel       = 2'd0;
        #1;
        checks++;
        assert (bus.data_out !== 8'h7C) else begin
            errors++;
            $error("FAIL bus_release: observed %h required not-driven (not %h)", bus.data_out, 8'h7C);
        end
        $display("check bus_release: observed %h", bus.data_out);

        // ADD with carry-out and wrap to zero
        do_op(2'd2, LOAD, 8'hF0, 1'b1);
        do_op(2'd2, ADD, 8'h20, 1'b1);
        read_acc("add1.acc2", 2'd2, 8'h10);
        check_flags("add1", 1'b1, 1'b0);
        do_op(2'd2, ADD, 8'hF0, 1'b1);
        read_acc("add2.acc2", 2'd2, 8'h00);
        check_flags("add2", 1'b1, 1'b1);

        // SUB with borrow, then exact zero
        do_op(2'd3, LOAD, 8'h05, 1'b1);
        do_op(2'd3, SUB, 8'h06, 1'b1);
        read_acc("sub1.acc3", 2'd3, 8'hFF);
        check_flags("sub1", 1'b1, 1'b0);
        do_op(2'd3, SUB, 8'hFF, 1'b1);
        read_acc("sub2.acc3", 2'd3, 8'h00);
        check_flags("sub2", 1'b0, 1'b1);
        do_op(2'd3, LOAD, 8'h12, 1'b1);
        read_acc("load.acc3", 2'd3, 8'h12);
        check_flags("load_keeps_flags", 1'b0, 1'b1);

        // Shifts on acc1
        do_op(2'd1, LOAD, 8'h81, 1'b1);
        do_op(2'd1, SHL, 8'h00, 1'b1);
        read_acc("shl.acc1", 2'd1, 8'h02);
        check_flags("shl", 1'b1, 1'b0);
        do_op(2'd1, SHR, 8'h00, 1'b1);
        read_acc("shr1.acc1", 2'd1, 8'h01);
        check_flags("shr1", 1'b0, 1'b0);
        do_op(2'd1, SHR, 8'h00, 1'b1);
        read_acc("shr2.acc1", 2'd1, 8'h00);
        check_flags("shr2", 1'b1, 1'b1);

        // op_valid low: nothing changes
        do_op(2'd1, LOAD, 8'hFF, 1'b0);
        do_op(2'd1, ADD, 8'h05, 1'b0);
        do_op(2'd1, SUB, 8'h01, 1'b0);
        read_acc("novalid.acc1", 2'd1, 8'h00);
        check_flags("novalid", 1'b1, 1'b1);
        read_acc("hold.acc0", 2'd0, 8'h7C);
        read_acc("hold.acc2", 2'd2, 8'h00);
        read_acc("hold.acc3", 2'd3, 8'h12);

        // Mid-sequence asynchronous reset
        do_op(2'd2, LOAD, 8'h30, 1'b1);
        do_op(2'd2, ADD, 8'hE0, 1'b1);
        read_acc("add3.acc2", 2'd2, 8'h10);
        check_flags("add3", 1'b1, 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check8("async_reset.acc2", bus.data_out, 8'h00);
        check_flags("async_reset", 1'b0, 1'b0);
        bus.acc_sel = 2'd0;
        #0.5;
        check8("async_reset.acc0", bus.data_out, 8'h00);
        #0.5;
        reset = 1'b0;

        // Read during write: old value before the edge, new value after
        @(negedge clk);
        bus.acc_sel       = 2'd0;
        bus.op            = LOAD;
        bus.data_in       = 8'h55;
        bus.op_valid      = 1'b1;
        bus.output_enable = 1'b1;
        #1;
        check8("rdw.before", bus.data_out, 8'h00);
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        check8("rdw.after", bus.data_out, 8'h55);
        check_flags("rdw", 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/accumulator_bank.md
Name: accumulator_bank

Overview:
- Parametrised successor to the single 8-bit accumulator.
- Holds NUM_ACC independent X-bit accumulators. Each can be loaded whole or by nibble-immediate, and can run ALU-lite operations (add, subtract, shift) with carry and zero flags.
- The selected accumulator drives the shared data bus through a tristate output.
- Sits between the instruction decoder (op/acc_sel) and the shared data bus.

Parameters:
- X, 8, accumulator and bus width; must be even and >= 4.
- NUM_ACC, 4, number of accumulators; power of two, >= 2.
- SEL_W, $clog2(NUM_ACC), width of acc_sel (derived; not overridden).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all accumulators and flags.
- data_in  input  X  operand/load value from the bus.
- acc_sel  input  SEL_W  accumulator targeted by op and driven on data_out.
- op  input  3  operation code (see Behaviour).
- op_valid  input  1  op is executed on this edge only when high.
- output_enable  input  1  drives the selected accumulator onto data_out; high-Z when low.
- data_out  output  X  tristate bus output.
- carry_flag  output  1  registered carry/borrow/shift-out from the last arithmetic op.
- zero_flag  output  1  registered, high when the last arithmetic result was zero.

Behaviour:
- Reset (asynchronous assert, held while high): all accumulators = 0, carry_flag = 0, zero_flag = 0. data_out = Z unless output_enable is high, in which case it reads 0.
- Ops apply on a rising clk edge with op_valid=1. A = acc[acc_sel], H = X/2.
  - 000 NOP: no change.
  - 001 LOAD: A <= data_in.
  - 010 LOAD_IMM_LO: A[H-1:0] <= data_in[H-1:0]; A[X-1:H] <= 0.
  - 011 LOAD_IMM_HI: A[X-1:H] <= data_in[H-1:0]; A[H-1:0] unchanged.
  - 100 ADD: {carry, A} <= A + data_in. Carry is the bit-X carry-out; the result wraps modulo 2^X.
  - 101 SUB: A <= A - data_in, modulo 2^X; carry <= 1 iff A < data_in (unsigned borrow).
  - 110 SHL: A <= {A[X-2:0], 0}; carry <= old A[X-1].
  - 111 SHR (logical): A <= {0, A[X-1:1]}; carry <= old A[0].
- Flags:
  - Updated only by ops 100-111, on the same edge as the result.
  - zero_flag <= (new A == 0).
  - NOP and loads leave both flags unchanged.
  - Flags are global, not per accumulator.
- op_valid=0: no accumulator or flag changes, whatever op is.
- Only acc[acc_sel] is modified; the other accumulators hold.
- Read path:
  - data_out = acc[acc_sel] combinationally when output_enable=1, else all bits Z.
  - A write shows on data_out after the edge; there is no same-cycle bypass.
  - acc_sel can change every cycle; the output follows combinationally.
- Simultaneous output_enable=1 and a write to the same accumulator: data_out shows the old value until the edge, then the new value.
- Reset asserted mid-sequence: state clears immediately, with no wait for clk. The first op after reset deasserts executes on the next rising edge.
- Latency: one clk for every op to become visible on data_out and flags.
- Full-width arithmetic: the result and flags are exact for any X. There is no saturation.

Test Plan (X=8, NUM_ACC=4):
- Reset with output_enable=1, acc_sel=0..3 -> data_out=0x00 for every select; carry=0, zero=0. Deassert, output_enable=0 -> data_out=ZZ.
- acc0 LOAD 0xA5; acc0 LOAD_IMM_LO 0x3C -> acc0=0x0C. Then LOAD_IMM_HI 0x07 -> acc0=0x7C. acc1..3 remain 0x00.
- acc2 LOAD 0xF0; ADD 0x20 -> acc2=0x10, carry=1, zero=0. ADD 0xF0 -> 0x00, carry=1, zero=1.
- acc3 LOAD 0x05; SUB 0x06 -> 0xFF, carry=1. SUB 0xFF -> 0x00, carry=0, zero=1. A subsequent LOAD 0x12 leaves the flags (0, 1) unchanged.
- acc1 LOAD 0x81; SHL -> 0x02, carry=1. SHR -> 0x01, carry=0. SHR -> 0x00, carry=1, zero=1. The same ops with op_valid=0 -> no change.
- Mid-sequence: after ADD on acc2, assert reset between clock edges -> data_out=0x00 and flags=0 before the next edge. A read of acc0 in the cycle of a LOAD 0x55 shows the old value, and shows 0x55 after the edge.
